clk_div_prog: RTL
=================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of divisor and phase counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, divisor applied out of reset.
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  divider run enable.
REQ-006 SHALL have port div_in  input  CNT_WIDTH  requested divisor N.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe capturing div_in.
REQ-008 SHALL have port clk_out  output  1  divided square wave, registered.
REQ-009 SHALL have port tick  output  1  one-cycle pulse per output period, registered.
REQ-010 SHALL have port div_active  output  CNT_WIDTH  divisor currently in effect.

Function
REQ-011 SHALL hold a pending divisor register and an active divisor register; div_load copies div_in into pending.
REQ-012 SHALL clamp captured div_in values 0 and 1 to 2.
REQ-013 SHALL copy pending to active only at a period boundary (cycle in which tick is asserted) or while en is low; never mid-period.
REQ-014 SHALL, when div_load coincides with a period boundary, apply the newly loaded value at that boundary.
REQ-015 SHALL run phase counter cnt 0..N-1, incrementing each cycle while en high, wrapping N-1 -> 0.
REQ-016 SHALL drive clk_out high for cnt in 0..floor(N/2)-1 and low otherwise (50% duty for even N; high floor(N/2), low ceil(N/2) cycles for odd N).
REQ-017 SHALL assert tick for exactly one cycle when cnt = N-1.
REQ-018 SHALL present clk_out and tick as flop outputs aligned with the cnt value they decode (computed from next-state), no combinational glitches.
REQ-019 SHALL, while en low, hold cnt at 0, clk_out 0, tick 0.
REQ-020 SHALL, on en rising, present cnt=0 and clk_out=1 in the first enabled cycle.
REQ-021 SHALL handle N = 2^CNT_WIDTH-1 without overflow; counter arithmetic SHALL be CNT_WIDTH bits wide.

Reset
REQ-022 SHALL, with rst high at a clock edge, set cnt=0, clk_out=0, tick=0, pending=active=DEFAULT_DIV (clamped per REQ-012).
REQ-023 SHALL give rst priority over en, div_load and burst inputs, including mid-period or mid-burst.
REQ-024 SHALL resume per REQ-020 on the first cycle after rst falls if en is high.

Configuration
REQ-025 SHALL support macro CLK_DIV_BURST_EN; when defined, ports burst_start (input 1), burst_len (input 16), burst_busy (output 1), burst_done (output 1) exist.
REQ-026 SHALL, with CLK_DIV_BURST_EN, on burst_start while en high, restart cnt at 0 next cycle, set burst_busy, emit exactly burst_len full periods, then hold clk_out 0, tick 0, cnt 0.
REQ-027 SHALL, with CLK_DIV_BURST_EN, assert burst_done for one cycle coinciding with the final tick and clear burst_busy the following cycle.
REQ-028 SHALL, with CLK_DIV_BURST_EN, treat burst_len=0 as: burst_done pulse the cycle after burst_start, no periods emitted; burst_start while burst_busy SHALL restart the burst.
REQ-029 SHALL, with CLK_DIV_BURST_EN, abort a burst when en falls (burst_busy cleared, no burst_done); outputs after reset and when idle SHALL be 0.
REQ-030 SHALL, without CLK_DIV_BURST_EN, omit the burst ports and run free whenever en is high.

Verification
REQ-031 Reset, en=1, DEFAULT_DIV=4 -> clk_out pattern 1,1,0,0 repeating; tick every 4th cycle at cnt=3; div_active=4.
REQ-032 div_in=5 with div_load mid-period -> current 4-cycle period completes, then clk_out 1,1,0,0,0 and tick every 5 cycles; div_active changes at that boundary.
REQ-033 div_in=0 and div_in=1 loads -> div_active=2, clk_out toggles every cycle, tick every 2nd cycle.
REQ-034 en dropped at cnt=2 for 3 cycles then raised -> outputs 0 while low; first enabled cycle cnt=0, clk_out=1.
REQ-035 rst asserted mid-period with pending divisor 7 -> next cycle outputs 0, div_active=DEFAULT_DIV, pending discarded.
REQ-036 With CLK_DIV_BURST_EN, N=3, burst_len=2 -> exactly 2 periods (6 cycles), burst_done on second tick, burst_busy low next cycle; burst_len=0 -> burst_done next cycle, clk_out stays 0.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free registered outputs.
// Divisor changes are double-buffered (pending -> active) and take effect
// only on a period boundary or while the divider is disabled.
// Optional feature: define CLK_DIV_BURST_EN to add a burst engine that emits
// a programmed number of periods per burst_start; outputs idle low otherwise.
module clk_div_prog #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
`ifdef CLK_DIV_BURST_EN
    input  logic                 burst_start,
    input  logic [15:0]          burst_len,
    output logic                 burst_busy,
    output logic                 burst_done,
`endif
    output logic                 clk_out,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] div_active
);

    // Divisors below 2 cannot form a period with both a high and low phase.
    function automatic logic [CNT_WIDTH-1:0] clamp2(input logic [CNT_WIDTH-1:0] v);
        return (v < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : v;
    endfunction

    localparam logic [CNT_WIDTH-1:0] RST_DIV = clamp2(CNT_WIDTH'(DEFAULT_DIV));

    logic [CNT_WIDTH-1:0] pending, active, cnt;
    logic [CNT_WIDTH-1:0] pend_eff, act_n, cnt_n;
    logic                 clk_out_q, tick_q;
    logic                 go, restart, upd, wrap;
    logic                 clk_out_n, tick_n;

`ifdef CLK_DIV_BURST_EN
    logic        busy, done_q, done_n;
    logic [15:0] rem;

    // Burst mode: run only inside a burst; a (re)start opens a fresh period.
    always_comb begin
        restart = en && burst_start && (burst_len != 16'd0);
        go      = restart || (en && !burst_start && busy && !done_q);
        upd     = !en || tick_q || !busy || restart;
    end
`else
    logic run_q;

    // Free-running mode: the first enabled cycle always starts at phase 0.
    always_comb begin
        go      = en;
        restart = en && !run_q;
        upd     = !en || tick_q;
    end

    // Remembers whether the previous cycle was enabled.
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= en;
    end
`endif

    // Next-state for divisor, phase counter and the decoded outputs.
    always_comb begin
        pend_eff  = div_load ? clamp2(div_in) : pending;
        act_n     = upd ? pend_eff : active;
        wrap      = (cnt == active - CNT_WIDTH'(1));
        cnt_n     = '0;
        if (go && !restart && !wrap) cnt_n = cnt + CNT_WIDTH'(1);
        clk_out_n = go && (cnt_n < (act_n >> 1));
        tick_n    = go && (cnt_n == act_n - CNT_WIDTH'(1));
    end

    // Divider state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= RST_DIV;
            active    <= RST_DIV;
            cnt       <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            pending   <= pend_eff;
            active    <= act_n;
            cnt       <= cnt_n;
            clk_out_q <= clk_out_n;
            tick_q    <= tick_n;
        end
    end

`ifdef CLK_DIV_BURST_EN
    // Final tick of a burst is the one issued with a single period remaining.
    always_comb done_n = busy && !done_q && tick_n && (rem == 16'd1);

    // Burst bookkeeping: period countdown, busy flag and done pulse.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            busy   <= 1'b0;
            done_q <= 1'b0;
            rem    <= '0;
        end else if (burst_start) begin
            busy   <= (burst_len != 16'd0);
            done_q <= (burst_len == 16'd0);
            rem    <= burst_len;
        end else begin
            done_q <= done_n;
            if (done_q) busy <= 1'b0;
            if (busy && !done_q && tick_q) rem <= rem - 16'd1;
        end
    end

    assign burst_busy = busy;
    assign burst_done = done_q;
`endif

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign div_active = active;

endmodule
